// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width, hex glyph
// table (active-high, bit0=a .. bit6=g), blank code and a polarity helper.
package seg7_pkg;

    localparam int SEG7_W = 7;

    // Index 15 first so that GLYPH_TABLE[n] is the glyph for nibble n.
    localparam logic [15:0][SEG7_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    localparam logic [SEG7_W-1:0] BLANK_GLYPH = 7'h00;

    function automatic logic [SEG7_W-1:0] apply_polarity(
        input logic [SEG7_W-1:0] glyph,
        input bit                active_low
    );
        if (active_low) begin
            return ~glyph;
        end else begin
            return glyph;
        end
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0]        nibble,
    output logic [SEG7_W-1:0] glyph
);

    // Table lookup; every nibble value has an entry.
    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver with frame-synchronous double-buffered updates.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    output logic [SEG7_W-1:0]   seg,
    output logic [DIGITS-1:0]   dig_en,
    output logic                pending,
    output logic                frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEG7_W-1:0] SEG_BLANK_OUT = apply_polarity(BLANK_GLYPH, SEG_ACTIVE_LOW);

    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] shadow_r;
    logic [4*DIGITS-1:0] display_r;
    logic                pending_r;
    logic                frame_done_r;
    logic [SEG7_W-1:0]   seg_r;
    logic [DIGITS-1:0]   dig_en_r;

    logic                cnt_wrap_s;
    logic                boundary_s;
    logic [4*DIGITS-1:0] disp_shift_s;
    logic [3:0]          nibble_s;
    logic [SEG7_W-1:0]   glyph_s;
    logic [SEG7_W-1:0]   glyph_vis_s;
    logic                blank_s;

    // Scan position decode: end of digit slot and end of frame.
    always_comb begin
        cnt_wrap_s   = (cnt_r == CNT_LAST);
        boundary_s   = cnt_wrap_s && (idx_r == IDX_LAST);
        disp_shift_s = display_r >> {idx_r, 2'b00};
        nibble_s     = disp_shift_s[3:0];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_s),
        .glyph  (glyph_s)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] upper_zero_s;
    logic [DIGITS-1:0] upper_zero_shift_s;

    // upper_zero_s[k]: nibble k and everything above it are zero.
    always_comb begin
        upper_zero_s = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            upper_zero_s[k] = ((display_r >> (4 * k)) == {(4*DIGITS){1'b0}});
        end
        upper_zero_shift_s = upper_zero_s >> idx_r;
        blank_s = (idx_r != {IDX_W{1'b0}}) && upper_zero_shift_s[0];
    end
`else
    // Every digit is shown, zeros included.
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Final glyph selection before polarity is applied.
    always_comb begin
        if (blank_s) begin
            glyph_vis_s = BLANK_GLYPH;
        end else begin
            glyph_vis_s = glyph_s;
        end
    end

    // Divider and digit index.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (cnt_wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Shadow/display double buffer; display only changes at a frame boundary.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow_r  <= {(4*DIGITS){1'b0}};
            display_r <= {(4*DIGITS){1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                display_r <= shadow_r;
            end
            if (load) begin
                shadow_r  <= value;
                pending_r <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seg_r        <= SEG_BLANK_OUT;
            dig_en_r     <= {DIGITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= apply_polarity(glyph_vis_s, SEG_ACTIVE_LOW);
            dig_en_r     <= DIGITS'(1) << idx_r;
            frame_done_r <= boundary_s;
        end
    end

    assign seg        = seg_r;
    assign dig_en     = dig_en_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4) using a
// frame-position reference model that queues expected outputs per cycle.
module tb_seg7_scan_driver;

    localparam int FRAME = 16;

    typedef struct packed {
        logic [3:0] dig_en;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        pending;
    logic        frame_done;

    int checks;
    int failures;

    exp_t        exp_q[$];
    int          m_pos;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    logic        m_pend;

    seg7_scan_driver #(
        .DIGITS         (4),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .seg        (seg),
        .dig_en     (dig_en),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Active-high hex glyphs, segment a = bit 0.
    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rst_v, input logic ld_v, input logic [15:0] val_v);
        exp_t e;
        exp_t got;
        int   d;
        logic [3:0] nib;
        logic [6:0] g;
        logic boundary;
        reset = rst_v;
        load  = ld_v;
        value = val_v;
        if (!rst_v) begin
            e = '{dig_en: 4'b0000, seg: 7'h7F, fd: 1'b0, pend: 1'b0};
            m_pos = 0; m_shadow = 16'h0000; m_disp = 16'h0000; m_pend = 1'b0;
        end else begin
            d   = m_pos / 4;
            nib = 4'((m_disp >> (4 * d)) & 16'h000F);
            g   = ref_glyph(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_disp >> (4 * d)) == 16'h0000) g = 7'h00;
`endif
            boundary = (m_pos == FRAME - 1);
            e.dig_en = 4'b0001 << d;
            e.seg    = ~g;
            e.fd     = boundary;
            if (boundary && m_pend) m_disp = m_shadow;
            if (ld_v) begin
                m_shadow = val_v;
                m_pend   = 1'b1;
            end else if (boundary) begin
                m_pend = 1'b0;
            end
            e.pend = m_pend;
            m_pos  = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        chk("dig_en",     {12'h000, dig_en},    {12'h000, got.dig_en});
        chk("seg",        {9'h000, seg},        {9'h000, got.seg});
        chk("frame_done", {15'h0000, frame_done}, {15'h0000, got.fd});
        chk("pending",    {15'h0000, pending},  {15'h0000, got.pend});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && m_pos != pos; i++) step(1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [6:0] lit_1a8f [4];
        checks = 0;
        failures = 0;
        reset = 1'b0; load = 1'b0; value = 16'h0000;
        m_pos = 0; m_shadow = 16'h0000; m_disp = 16'h0000; m_pend = 1'b0;
        lit_1a8f = '{7'h0E, 7'h00, 7'h08, 7'h79};

        // Reset, then two idle frames showing 0000.
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000);
        chk("reset_seg", {9'h000, seg}, 16'h007F);
        step(1'b1, 1'b0, 16'h0000);
        chk("first_dig_en", {12'h000, dig_en}, 16'h0001);
        chk("first_seg", {9'h000, seg}, 16'h0040);
        idle(2 * FRAME - 1);

        // Mid-frame load of 1A8F, applied at the next boundary.
        run_to(5);
        step(1'b1, 1'b1, 16'h1A8F);
        chk("pend_after_load", {15'h0000, pending}, 16'h0001);
        run_to(0);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 1'b0, 16'h0000);
                chk("lit_1a8f", {9'h000, seg}, {9'h000, lit_1a8f[d]});
            end
        end
        chk("pend_cleared", {15'h0000, pending}, 16'h0000);

        // Two loads in one frame: last wins.
        run_to(3);
        step(1'b1, 1'b1, 16'h1111);
        run_to(7);
        step(1'b1, 1'b1, 16'h2222);
        idle(2 * FRAME + 4);

        // Load exactly on the boundary cycle with nothing pending.
        run_to(FRAME - 1);
        step(1'b1, 1'b1, 16'h3333);
        chk("pend_boundary_load", {15'h0000, pending}, 16'h0001);
        idle(2 * FRAME + 2);

        // Reset during digit 2 of a pending update.
        run_to(2);
        step(1'b1, 1'b1, 16'h4444);
        run_to(9);
        step(1'b0, 1'b0, 16'h0000);
        chk("mid_reset_seg", {9'h000, seg}, 16'h007F);
        chk("mid_reset_dig", {12'h000, dig_en}, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        idle(2 * FRAME);
        chk("after_reset_pend", {15'h0000, pending}, 16'h0000);

        // 0050: leading zeros blank only when the feature is compiled in.
        step(1'b1, 1'b1, 16'h0050);
        idle(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of hex digits; legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit stays lit; legal minimum 2.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1 a lit segment drives 0, when 0 a lit segment drives 1.
REQ-004 SHALL have port clock  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port load  input  1  single-cycle strobe capturing value.
REQ-007 SHALL have port value  input  4*DIGITS  hex word; nibble k drives digit k, nibble 0 is least significant.
REQ-008 SHALL have port seg  output  7  segment bus, bit0=a ... bit6=g, registered.
REQ-009 SHALL have port dig_en  output  DIGITS  one-hot active-high digit select, registered.
REQ-010 SHALL have port pending  output  1  high while a captured value awaits a frame boundary.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL keep a divider cnt counting 0..SCAN_DIV-1, wrapping to 0, and a digit index idx that advances by 1 when cnt==SCAN_DIV-1.
REQ-013 SHALL wrap idx from DIGITS-1 to 0; that cycle (idx==DIGITS-1, cnt==SCAN_DIV-1) is the frame boundary.
REQ-014 SHALL drive frame_done high for exactly the frame-boundary cycle, registered; it is asserted on the cycle after the boundary.
REQ-015 SHALL register seg and dig_en from idx and the display register with one cycle of latency: dig_en has only bit idx set, and seg holds the decoded nibble idx.
REQ-016 SHALL decode nibbles 0-F to standard hex glyphs (b and d lowercase). With SEG_ACTIVE_LOW=1 the codes are 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E, and blank is 7'h7F.
REQ-017 SHALL write value into a shadow register and set pending on load.
REQ-018 SHALL copy shadow into the display register and clear pending at a frame boundary when pending=1, so there is no mid-frame tearing.
REQ-019 SHALL handle repeated loads while pending=1 as last-wins: shadow is overwritten and only one frame update occurs.
REQ-020 SHALL handle load coincident with a frame boundary as follows:
- the display takes the old shadow if pending was 1, otherwise it is unchanged;
- shadow takes the new value;
- pending ends the cycle as 1.
REQ-021 SHALL ignore load while reset is asserted.

Reset
REQ-022 SHALL, on a clock edge with reset=0, clear cnt, idx, shadow, display register, pending and frame_done, drive dig_en to all zeros and drive seg to blank.
REQ-023 SHALL drive dig_en=1 (digit 0) and seg=the code for '0' on the first edge after reset is released.
REQ-024 SHALL, on reset during an active frame, abandon the frame and discard any pending value.

Configuration
REQ-025 SHALL support macro SEG7_LEADING_ZERO_BLANK_EN. When defined, a digit k>0 whose nibble and all higher nibbles in the display register are zero is driven blank, with dig_en unchanged; digit 0 is never blanked.
REQ-026 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display every digit, zeros included.

Structure
REQ-027 SHALL take the 16-entry glyph table, the blank code and the SEG7_W=7 constant from shared package seg7_pkg.
REQ-028 SHALL place the decode in combinational sub-module hex_to_seg7 (4-bit nibble in, 7-bit active-high glyph out); the active-low inversion is applied in seg7_scan_driver.

Verification
REQ-029 SHALL be verified with DIGITS=4 and SCAN_DIV=4 for all of the following scenarios.
- Reset, then release -> dig_en cycles 0001, 0010, 0100, 1000 every 4 cycles; seg=7'h40 throughout; frame_done pulses every 16 cycles.
- Load 16'h1A8F mid-frame -> pending=1, and digits keep showing 0 until the boundary. From the next frame the digits read 0 -> 7'h0E, 1 -> 7'h00, 2 -> 7'h08, 3 -> 7'h79, and pending=0.
- Load 16'h1111 then 16'h2222 in the same frame -> only 2222 is ever displayed.
- Load 16'h3333 exactly on the boundary cycle with pending=0 -> the display stays unchanged for one frame, then shows 3333.
- Assert reset during digit 2 of a pending update -> seg=7'h7F and dig_en=0; after release the display shows 0000 and pending=0.
- With SEG7_LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 are blank, digit 1 is 7'h12 and digit 0 is 7'h40.
